// File: rtl/cpu6_clint_pkg.sv
// rtl/cpu6_clint_pkg.sv - CLINT register map, window base and offset decode helper
package cpu6_clint_pkg;

  localparam logic [31:0] CPU6_CLINT_BASE            = 32'h0200_0000;
  localparam logic [15:0] CPU6_CLINT_MSIP_OFS        = 16'h0000;
  localparam logic [15:0] CPU6_CLINT_MTIMECMP_LO_OFS = 16'h4000;
  localparam logic [15:0] CPU6_CLINT_MTIMECMP_HI_OFS = 16'h4004;
  localparam logic [15:0] CPU6_CLINT_MTIME_LO_OFS    = 16'hBFF8;
  localparam logic [15:0] CPU6_CLINT_MTIME_HI_OFS    = 16'hBFFC;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_MTIME_LO,
    REG_MTIME_HI
  } regSel_e;

  // Word accesses only: the byte-lane bits of the offset are masked off.
  function automatic regSel_e decodeOfs(input logic [15:0] ofs);
    logic [15:0] wordOfs;
    wordOfs = ofs & 16'hFFFC;
    case (wordOfs)
      CPU6_CLINT_MSIP_OFS:        decodeOfs = REG_MSIP;
      CPU6_CLINT_MTIMECMP_LO_OFS: decodeOfs = REG_CMP_LO;
      CPU6_CLINT_MTIMECMP_HI_OFS: decodeOfs = REG_CMP_HI;
      CPU6_CLINT_MTIME_LO_OFS:    decodeOfs = REG_MTIME_LO;
      CPU6_CLINT_MTIME_HI_OFS:    decodeOfs = REG_MTIME_HI;
      default:                    decodeOfs = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu6_clint_prescaler.sv
// rtl/cpu6_clint_prescaler.sv - mtime tick generator, one tick every PRESCALE cycles
module cpu6_clint_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [W-1:0] count;

  assign tick = (count == W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu6_clint.sv
// rtl/cpu6_clint.sv - machine timer / software interrupt unit on the MEM-stage data port
module cpu6_clint
  import cpu6_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = CPU6_CLINT_BASE,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tmr_irq_r,
  output logic        sw_irq_r
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [63:0] mtimeNext;
  logic        tick;
  logic        wrEn;
  regSel_e     sel;

  cpu6_clint_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign hit  = (addr[31:16] == BASE_ADDR[31:16]);
  assign sel  = decodeOfs(addr[15:0]);
  assign wrEn = we & hit;

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        REG_MSIP:     rdata = {31'b0, msip};
        REG_CMP_LO:   rdata = mtimecmp[31:0];
        REG_CMP_HI:   rdata = mtimecmp[63:32];
        REG_MTIME_LO: rdata = mtime[31:0];
        REG_MTIME_HI: rdata = mtime[63:32];
        default:      rdata = '0;
      endcase
    end
  end

  // A software write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    mtimeNext = mtime;
    if (wrEn && sel == REG_MTIME_LO) begin
      mtimeNext = {mtime[63:32], wdata};
    end else if (wrEn && sel == REG_MTIME_HI) begin
      mtimeNext = {wdata, mtime[31:0]};
    end else if (tick) begin
      mtimeNext = mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      tmr_irq_r <= 1'b0;
      sw_irq_r  <= 1'b0;
    end else begin
      mtime     <= mtimeNext;
      tmr_irq_r <= (mtime >= mtimecmp);
      sw_irq_r  <= msip;
      if (wrEn) begin
        case (sel)
          REG_MSIP:   msip           <= wdata[0];
          REG_CMP_LO: mtimecmp[31:0]  <= wdata;
          REG_CMP_HI: mtimecmp[63:32] <= wdata;
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu6_clint.sv
// tb/tb_cpu6_clint.sv - scoreboard bench for cpu6_clint at PRESCALE 1 and 4
module tb_cpu6_clint;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;

  logic        hit1, hit4;
  logic [31:0] rdata1, rdata4;
  logic        tmr1, tmr4, sw1, sw4;

  always #5 clk = ~clk;

  cpu6_clint #(.BASE_ADDR(32'h0200_0000), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .hit(hit1), .rdata(rdata1), .tmr_irq_r(tmr1), .sw_irq_r(sw1)
  );

  cpu6_clint #(.BASE_ADDR(32'h0200_0000), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .hit(hit4), .rdata(rdata4), .tmr_irq_r(tmr4), .sw_irq_r(sw4)
  );

  typedef struct {
    logic        hit;
    logic [31:0] rd [2];
    logic        tmr [2];
    logic        sw [2];
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state per instance: index 0 is PRESCALE=1, index 1 is PRESCALE=4.
  int          pres [2] = '{1, 4};
  logic [63:0] mMtime [2];
  logic [63:0] mCmp [2];
  logic        mMsip [2];
  int          mCycles [2];
  logic        mTmr [2];
  logic        mSw [2];

  function automatic logic inWindow(input logic [31:0] a);
    return a[31:16] == 16'h0200;
  endfunction

  function automatic logic [31:0] modelRead(input int i, input logic [31:0] a);
    logic [15:0] off;
    off = a[15:0] & 16'hFFFC;
    if (!inWindow(a)) return 32'h0;
    case (off)
      16'h0000: return {31'b0, mMsip[i]};
      16'h4000: return mCmp[i][31:0];
      16'h4004: return mCmp[i][63:32];
      16'hBFF8: return mMtime[i][31:0];
      16'hBFFC: return mMtime[i][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mMtime[i] = 64'h0;
      mCmp[i] = '1;
      mMsip[i] = 1'b0;
      mCycles[i] = 0;
      mTmr[i] = 1'b0;
      mSw[i] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge with the inputs held during the cycle before it.
  task automatic modelEdge(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w);
    logic [15:0] off;
    logic        tickNow;
    logic        mtWritten;
    if (r) begin
      modelReset();
      return;
    end
    off = a[15:0] & 16'hFFFC;
    for (int i = 0; i < 2; i++) begin
      tickNow = (mCycles[i] % pres[i]) == pres[i] - 1;
      mCycles[i]++;
      mTmr[i] = mMtime[i] >= mCmp[i];
      mSw[i] = mMsip[i];
      mtWritten = 1'b0;
      if (w && inWindow(a)) begin
        if (off == 16'h0000) mMsip[i] = d[0];
        if (off == 16'h4000) mCmp[i][31:0] = d;
        if (off == 16'h4004) mCmp[i][63:32] = d;
        if (off == 16'hBFF8) begin mMtime[i][31:0] = d; mtWritten = 1'b1; end
        if (off == 16'hBFFC) begin mMtime[i][63:32] = d; mtWritten = 1'b1; end
      end
      if (tickNow && !mtWritten) mMtime[i] = mMtime[i] + 64'd1;
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d, input logic w);
    exp_t e;
    @(posedge clk);
    #1;
    modelEdge(reset, addr, wdata, we);
    reset = r;
    addr = a;
    wdata = d;
    we = w;
    e.hit = inWindow(a);
    for (int i = 0; i < 2; i++) begin
      e.rd[i] = modelRead(i, a);
      e.tmr[i] = mTmr[i];
      e.sw[i] = mSw[i];
    end
    expQ.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t addr=%h actual=%h required=%h", name, $time, addr, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      check("hit1", {31'b0, hit1}, {31'b0, e.hit});
      check("hit4", {31'b0, hit4}, {31'b0, e.hit});
      check("rdata1", rdata1, e.rd[0]);
      check("rdata4", rdata4, e.rd[1]);
      check("tmr1", {31'b0, tmr1}, {31'b0, e.tmr[0]});
      check("tmr4", {31'b0, tmr4}, {31'b0, e.tmr[1]});
      check("sw1", {31'b0, sw1}, {31'b0, e.sw[0]});
      check("sw4", {31'b0, sw4}, {31'b0, e.sw[1]});
    end
  end

  localparam logic [31:0] A_MSIP = 32'h0200_0000;
  localparam logic [31:0] A_CLO  = 32'h0200_4000;
  localparam logic [31:0] A_CHI  = 32'h0200_4004;
  localparam logic [31:0] A_TLO  = 32'h0200_BFF8;
  localparam logic [31:0] A_THI  = 32'h0200_BFFC;

  logic [31:0] addrPool [7] = '{A_MSIP, A_CLO, A_CHI, A_TLO, A_THI, 32'h0200_0100, 32'h0300_BFF8};

  initial begin
    logic [31:0] ra, rd;
    modelReset();
    cyc(1, A_TLO, 0, 0);
    cyc(1, A_TLO, 0, 0);
    // Reset values of every register.
    cyc(0, A_TLO, 0, 0);
    cyc(0, A_THI, 0, 0);
    cyc(0, A_CLO, 0, 0);
    cyc(0, A_CHI, 0, 0);
    cyc(0, A_MSIP, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, A_TLO, 0, 0);
    // Timer compare crossing, then software raising mtimecmp.
    cyc(1, A_TLO, 0, 0);
    cyc(0, A_CHI, 32'h0, 1);
    cyc(0, A_CLO, 32'h5, 1);
    for (int k = 0; k < 8; k++) cyc(0, A_TLO, 0, 0);
    cyc(0, A_CLO, 32'd100, 1);
    for (int k = 0; k < 4; k++) cyc(0, A_TLO, 0, 0);
    // Carry from mtime_lo into mtime_hi, and a write colliding with a tick.
    cyc(0, A_TLO, 32'hFFFF_FFFF, 1);
    cyc(0, A_THI, 32'h0, 1);
    for (int k = 0; k < 6; k++) cyc(0, (k % 2) ? A_THI : A_TLO, 0, 0);
    cyc(0, A_TLO, 32'h1234, 1);
    cyc(0, A_TLO, 0, 0);
    cyc(0, A_THI, 0, 0);
    // Software interrupt bit.
    cyc(0, A_MSIP, 32'hFFFF_FFFF, 1);
    cyc(0, A_MSIP, 0, 0);
    cyc(0, A_MSIP, 0, 0);
    cyc(0, A_MSIP, 32'h0, 1);
    cyc(0, A_MSIP, 0, 0);
    cyc(0, A_MSIP, 0, 0);
    // Out-of-window write, unmapped offset, byte-lane bits ignored.
    cyc(0, 32'h0300_BFF8, 32'hDEAD_BEEF, 1);
    cyc(0, A_TLO, 0, 0);
    cyc(0, 32'h0200_0100, 32'h5555_5555, 1);
    cyc(0, 32'h0200_0100, 0, 0);
    cyc(0, A_TLO | 32'h3, 0, 0);
    // Reset asserted mid-count.
    for (int k = 0; k < 6; k++) cyc(0, A_TLO, 0, 0);
    cyc(1, A_TLO, 0, 0);
    for (int k = 0; k < 9; k++) cyc(0, (k == 4) ? A_CLO : A_TLO, 0, 0);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      ra = addrPool[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) ra = $urandom;
      ra = ra ^ {30'b0, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 3))
        0: rd = $urandom_range(0, 64);
        1: rd = 32'hFFFF_FFFF - $urandom_range(0, 3);
        2: rd = 32'h0;
        default: rd = $urandom;
      endcase
      cyc(($urandom_range(0, 199) == 0), ra, rd, ($urandom_range(0, 9) < 3));
    end
    cyc(0, A_TLO, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
